armleocpu_cache_arbiter: RTL and testbench
==========================================

Name: armleocpu_cache_arbiter

Overview:
- Shares one cache port between two requesters: the fetch unit (requester F) and the execute/memory data path (requester D).
- Sits between both requesters and the single cache instance. Both requesters see the unchanged cache command/response protocol, so neither needs to know the port is shared.
- Arbitrates at each command boundary and locks the port to the owner until the cache returns a terminal response.

Parameters:
- ROUND_ROBIN, 1: 1 = round-robin between F and D on a tie; 0 = fixed priority, D always wins a tie.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_reset_done  in  1  cache finished its internal reset; gates arbitration.
- f_cmd  in  4  fetch cache command (CACHE_CMD_*).
- f_address  in  32  fetch address.
- f_response  out  4  response routed to fetch (CACHE_RESPONSE_*).
- f_load_data  out  32  load data routed to fetch.
- d_cmd  in  4  data cache command.
- d_address  in  32  data address.
- d_load_type  in  3  data load type.
- d_store_type  in  2  data store type.
- d_store_data  in  32  data store data.
- d_response  out  4  response routed to data requester.
- d_load_data  out  32  load data routed to data requester.
- c_cmd  out  4  command to cache.
- c_address  out  32  address to cache.
- c_load_type  out  3  load type to cache.
- c_store_type  out  2  store type to cache.
- c_store_data  out  32  store data to cache.
- c_response  in  4  cache response.
- c_load_data  in  32  cache load data.
- arb_owner  out  2  registered current owner: NONE, FETCH or DATA (perf/debug).

Behaviour:
State and reset:
- Registers: owner (NONE/FETCH/DATA) and last_owner (FETCH/DATA).
- rst=1 at a clock edge sets owner=NONE and last_owner=FETCH, so D wins the first tie.
- While rst=1, combinationally: c_cmd=NONE, f_response=d_response=IDLE.
- Reset mid-transaction drops the lock; the cache result of that transaction is discarded.
- While c_reset_done=0: c_cmd=NONE, both responses IDLE, owner forced to NONE.

Free cycle:
- free = (owner==NONE) || (c_response != WAIT). A terminal response (DONE, ACCESSFAULT, MISSALIGNED, PAGEFAULT) or IDLE ends the lock.
- Candidates are requesters whose cmd != NONE.
- Tie: winner = the requester that is not last_owner (ROUND_ROBIN=1), or D (ROUND_ROBIN=0).
- The winner's cmd, address and type/data are driven onto c_* combinationally in the same cycle. D's load/store type and data pass through; when F is selected, c_load_type, c_store_type and c_store_data are 0.
- Next owner = winner, next last_owner = winner.
- No candidate: c_cmd=NONE, next owner=NONE, last_owner unchanged.
- Zero-cycle arbitration latency: a requester that issues a new command on the cycle it receives DONE is forwarded that cycle, matching the existing fetch pipelined issue.

Busy cycle (not free):
- The owner's signals are forwarded transparently to c_*, including re-issued commands. The cache ignores cmd while in WAIT.
- The other requester's cmd is not forwarded.

Response routing (every cycle):
- The previous owner (registered owner) receives c_response and c_load_data unchanged.
- Any other requester receives WAIT if its cmd != NONE, otherwise IDLE. This covers a winner that differs from the previous owner in a free cycle.
- Load data to a non-owner is 0.

Commands and fairness:
- FLUSH_ALL and every other command are arbitrated identically. The lock holds until the flush DONE, so the other requester cannot interleave.
- Starvation bound (ROUND_ROBIN=1): a waiting requester is granted within one foreign transaction.
- A simultaneous terminal response and new commands from both requesters is the normal case: respond to the old owner and grant the new winner in the same cycle.

Decomposition:
- Add owner encodings ARMLEOCPU_ARB_OWNER_NONE/FETCH/DATA (2 bits) to armleocpu_defines.vh, next to the existing CACHE_CMD_* and CACHE_RESPONSE_* codes.
- A helper wire is_terminal(c_response) is local.
- No sub-module needed; a two-way pick function stays inline.

Test Plan:
1. After rst: f_cmd=EXECUTE at 0x2000, d_cmd=NONE -> c_cmd=EXECUTE, c_address=0x2000 the same cycle; arb_owner=FETCH next cycle. Cache returns DONE with load data 0x00000013 -> f_load_data=0x00000013, d_response=IDLE.
2. Tie right after rst: f_cmd=EXECUTE 0x2000, d_cmd=LOAD 0x8000 -> D granted first, f_response=WAIT. On D's DONE, F is granted the same cycle (c_address=0x2000); the next tie is won by D.
3. ROUND_ROBIN=0 with continuous D loads -> F sees WAIT until d_cmd=NONE, then is granted on the next free cycle.
4. D issues FLUSH_ALL and the cache holds WAIT for 20 cycles while f_cmd=EXECUTE -> c_cmd never shows F's command; F is granted only on the flush DONE cycle.
5. F owns the port and the cache returns PAGEFAULT -> f_response=PAGEFAULT, d_response=WAIT (d_cmd pending). D is granted the same cycle.
6. rst pulsed while D owns the port in WAIT -> c_cmd=NONE that cycle; arb_owner=NONE next cycle. The later DONE is not delivered to D. c_reset_done=0 -> both responses IDLE.

Source files
------------

// File: rtl/armleocpu_cache_arbiter_pkg.sv
// Shared cache command/response codes and arbiter owner encodings.
// Imported by the cache port arbiter.
package armleocpu_cache_arbiter_pkg;

    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_LOAD      = 4'd2;
    localparam logic [3:0] CACHE_CMD_STORE     = 4'd3;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd4;
    localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd5;

    typedef enum logic [1:0] {
        ARMLEOCPU_ARB_OWNER_NONE  = 2'd0,
        ARMLEOCPU_ARB_OWNER_FETCH = 2'd1,
        ARMLEOCPU_ARB_OWNER_DATA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] address;
        logic [2:0]  load_type;
        logic [1:0]  store_type;
        logic [31:0] store_data;
    } cache_req_t;

    // On a tie, round-robin hands the port to whoever did not own it last.
    function automatic owner_t arb_pick(
        input logic   f_req,
        input logic   d_req,
        input owner_t last_owner,
        input logic   round_robin
    );
        owner_t win;
        win = ARMLEOCPU_ARB_OWNER_NONE;
        if (f_req && d_req) begin
            if (round_robin && last_owner == ARMLEOCPU_ARB_OWNER_DATA)
                win = ARMLEOCPU_ARB_OWNER_FETCH;
            else
                win = ARMLEOCPU_ARB_OWNER_DATA;
        end else if (d_req) begin
            win = ARMLEOCPU_ARB_OWNER_DATA;
        end else if (f_req) begin
            win = ARMLEOCPU_ARB_OWNER_FETCH;
        end
        return win;
    endfunction

endpackage

// File: rtl/armleocpu_cache_arbiter.sv
// Shares one cache port between fetch (F) and data (D) requesters,
// locking the port to its owner until a non-WAIT cache response.
module armleocpu_cache_arbiter
    import armleocpu_cache_arbiter_pkg::*;
#(
    parameter logic ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_reset_done,

    input  logic [3:0]  f_cmd,
    input  logic [31:0] f_address,
    output logic [3:0]  f_response,
    output logic [31:0] f_load_data,

    input  logic [3:0]  d_cmd,
    input  logic [31:0] d_address,
    input  logic [2:0]  d_load_type,
    input  logic [1:0]  d_store_type,
    input  logic [31:0] d_store_data,
    output logic [3:0]  d_response,
    output logic [31:0] d_load_data,

    output logic [3:0]  c_cmd,
    output logic [31:0] c_address,
    output logic [2:0]  c_load_type,
    output logic [1:0]  c_store_type,
    output logic [31:0] c_store_data,
    input  logic [3:0]  c_response,
    input  logic [31:0] c_load_data,

    output logic [1:0]  arb_owner
);

    owner_t owner;
    owner_t owner_next;
    owner_t last_owner;
    owner_t last_owner_next;
    owner_t sel;

    logic active;
    logic free;
    logic f_req;
    logic d_req;

    cache_req_t f_bus;
    cache_req_t d_bus;
    cache_req_t c_bus;

    assign active = !rst && c_reset_done;
    assign free   = (owner == ARMLEOCPU_ARB_OWNER_NONE)
                 || (c_response != CACHE_RESPONSE_WAIT);
    assign f_req  = (f_cmd != CACHE_CMD_NONE);
    assign d_req  = (d_cmd != CACHE_CMD_NONE);

    // Fetch never carries load/store qualifiers onto the cache port.
    assign f_bus = '{
        cmd:        f_cmd,
        address:    f_address,
        load_type:  3'd0,
        store_type: 2'd0,
        store_data: 32'd0
    };

    assign d_bus = '{
        cmd:        d_cmd,
        address:    d_address,
        load_type:  d_load_type,
        store_type: d_store_type,
        store_data: d_store_data
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= ARMLEOCPU_ARB_OWNER_NONE;
            last_owner <= ARMLEOCPU_ARB_OWNER_FETCH;
        end else begin
            owner      <= owner_next;
            last_owner <= last_owner_next;
        end
    end

    always_comb begin
        sel             = ARMLEOCPU_ARB_OWNER_NONE;
        owner_next      = owner;
        last_owner_next = last_owner;
        if (!active) begin
            owner_next = ARMLEOCPU_ARB_OWNER_NONE;
        end else if (free) begin
            sel        = arb_pick(f_req, d_req, last_owner, ROUND_ROBIN);
            owner_next = sel;
            if (sel != ARMLEOCPU_ARB_OWNER_NONE)
                last_owner_next = sel;
        end else begin
            sel = owner;
        end
    end

    always_comb begin
        c_bus = '0;
        unique case (sel)
            ARMLEOCPU_ARB_OWNER_FETCH: c_bus = f_bus;
            ARMLEOCPU_ARB_OWNER_DATA:  c_bus = d_bus;
            default:                   c_bus = '0;
        endcase
    end

    assign c_cmd        = c_bus.cmd;
    assign c_address    = c_bus.address;
    assign c_load_type  = c_bus.load_type;
    assign c_store_type = c_bus.store_type;
    assign c_store_data = c_bus.store_data;

    // The registered owner gets the cache result; everyone else just waits.
    always_comb begin
        f_response  = CACHE_RESPONSE_IDLE;
        f_load_data = 32'd0;
        d_response  = CACHE_RESPONSE_IDLE;
        d_load_data = 32'd0;
        if (active) begin
            if (owner == ARMLEOCPU_ARB_OWNER_FETCH) begin
                f_response  = c_response;
                f_load_data = c_load_data;
            end else if (f_req) begin
                f_response = CACHE_RESPONSE_WAIT;
            end
            if (owner == ARMLEOCPU_ARB_OWNER_DATA) begin
                d_response  = c_response;
                d_load_data = c_load_data;
            end else if (d_req) begin
                d_response = CACHE_RESPONSE_WAIT;
            end
        end
    end

    assign arb_owner = owner;

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic
// checked against a behavioural model, for both arbitration modes.
module tb_armleocpu_cache_arbiter;

    localparam logic [3:0] C_NONE  = 4'd0;
    localparam logic [3:0] C_EXEC  = 4'd1;
    localparam logic [3:0] C_LOAD  = 4'd2;
    localparam logic [3:0] C_STORE = 4'd3;
    localparam logic [3:0] C_FLUSH = 4'd4;
    localparam logic [3:0] R_IDLE  = 4'd0;
    localparam logic [3:0] R_WAIT  = 4'd1;
    localparam logic [3:0] R_DONE  = 4'd2;
    localparam logic [3:0] R_PF    = 4'd5;

    logic        clk;
    logic        rst;
    logic        c_reset_done;
    logic [3:0]  f_cmd;
    logic [31:0] f_address;
    logic [3:0]  d_cmd;
    logic [31:0] d_address;
    logic [2:0]  d_load_type;
    logic [1:0]  d_store_type;
    logic [31:0] d_store_data;
    logic [3:0]  c_response;
    logic [31:0] c_load_data;

    logic [3:0]  r_f_response, p_f_response;
    logic [31:0] r_f_load_data, p_f_load_data;
    logic [3:0]  r_d_response, p_d_response;
    logic [31:0] r_d_load_data, p_d_load_data;
    logic [3:0]  r_c_cmd, p_c_cmd;
    logic [31:0] r_c_address, p_c_address;
    logic [2:0]  r_c_load_type, p_c_load_type;
    logic [1:0]  r_c_store_type, p_c_store_type;
    logic [31:0] r_c_store_data, p_c_store_data;
    logic [1:0]  r_arb_owner, p_arb_owner;

    int n_checks;
    int n_fail;

    armleocpu_cache_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .c_reset_done(c_reset_done),
        .f_cmd(f_cmd), .f_address(f_address),
        .f_response(r_f_response), .f_load_data(r_f_load_data),
        .d_cmd(d_cmd), .d_address(d_address),
        .d_load_type(d_load_type), .d_store_type(d_store_type),
        .d_store_data(d_store_data),
        .d_response(r_d_response), .d_load_data(r_d_load_data),
        .c_cmd(r_c_cmd), .c_address(r_c_address),
        .c_load_type(r_c_load_type), .c_store_type(r_c_store_type),
        .c_store_data(r_c_store_data),
        .c_response(c_response), .c_load_data(c_load_data),
        .arb_owner(r_arb_owner)
    );

    armleocpu_cache_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .c_reset_done(c_reset_done),
        .f_cmd(f_cmd), .f_address(f_address),
        .f_response(p_f_response), .f_load_data(p_f_load_data),
        .d_cmd(d_cmd), .d_address(d_address),
        .d_load_type(d_load_type), .d_store_type(d_store_type),
        .d_store_data(d_store_data),
        .d_response(p_d_response), .d_load_data(p_d_load_data),
        .c_cmd(p_c_cmd), .c_address(p_c_address),
        .c_load_type(p_c_load_type), .c_store_type(p_c_store_type),
        .c_store_data(p_c_store_data),
        .c_response(c_response), .c_load_data(c_load_data),
        .arb_owner(p_arb_owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        f_cmd = C_NONE;
        f_address = 32'd0;
        d_cmd = C_NONE;
        d_address = 32'd0;
        d_load_type = 3'd0;
        d_store_type = 2'd0;
        d_store_data = 32'd0;
        c_response = R_IDLE;
        c_load_data = 32'd0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        c_reset_done = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: owner codes 0=none, 1=fetch, 2=data.
    function automatic int model_gnt(input bit rr, input int mo, input int ml);
        bit fw, dw;
        fw = (f_cmd != C_NONE);
        dw = (d_cmd != C_NONE);
        if (rst || !c_reset_done) return 0;
        if (mo != 0 && c_response == R_WAIT) return mo;
        if (fw && dw) return (rr && ml == 2) ? 1 : 2;
        if (dw) return 2;
        if (fw) return 1;
        return 0;
    endfunction

    function automatic logic [146:0] model_out(input bit rr, input int mo, input int ml);
        int g;
        bit en;
        logic [72:0] cb;
        logic [3:0] fr, dr;
        logic [31:0] fl, dl;
        g = model_gnt(rr, mo, ml);
        en = !rst && c_reset_done;
        if (g == 1) cb = {f_cmd, f_address, 37'd0};
        else if (g == 2) cb = {d_cmd, d_address, d_load_type, d_store_type, d_store_data};
        else cb = '0;
        fr = R_IDLE; fl = 0; dr = R_IDLE; dl = 0;
        if (en) begin
            if (mo == 1) begin fr = c_response; fl = c_load_data; end
            else if (f_cmd != C_NONE) fr = R_WAIT;
            if (mo == 2) begin dr = c_response; dl = c_load_data; end
            else if (d_cmd != C_NONE) dr = R_WAIT;
        end
        return {cb, fr, fl, dr, dl, 2'(mo)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        c_reset_done = 1'b1;
        idle_inputs();
        f_cmd = C_EXEC;
        d_cmd = C_LOAD;
        @(negedge clk);
        n_checks++;
        if (r_c_cmd !== C_NONE) begin
            n_fail++; $display("FAIL reset_c_cmd got %h want %h", r_c_cmd, C_NONE);
        end
        n_checks++;
        if ({r_f_response, r_d_response} !== {R_IDLE, R_IDLE}) begin
            n_fail++; $display("FAIL reset_resp got %h/%h want 0/0", r_f_response, r_d_response);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (r_arb_owner !== 2'd0) begin
            n_fail++; $display("FAIL reset_owner got %0d want 0", r_arb_owner);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch_only;
        do_reset();
        f_cmd = C_EXEC;
        f_address = 32'h2000;
        d_load_type = 3'd5;
        d_store_type = 2'd3;
        d_store_data = 32'hffff_ffff;
        @(negedge clk);
        n_checks++;
        if ({r_c_cmd, r_c_address} !== {C_EXEC, 32'h2000}) begin
            n_fail++; $display("FAIL fetch_grant got %h %h want 1 2000", r_c_cmd, r_c_address);
        end
        n_checks++;
        if ({r_c_load_type, r_c_store_type, r_c_store_data} !== 37'd0) begin
            n_fail++; $display("FAIL fetch_zero_types got %h %h %h want 0", r_c_load_type, r_c_store_type, r_c_store_data);
        end
        tick();
        f_cmd = C_NONE;
        c_response = R_DONE;
        c_load_data = 32'h0000_0013;
        @(negedge clk);
        n_checks++;
        if (r_arb_owner !== 2'd1) begin
            n_fail++; $display("FAIL fetch_owner got %0d want 1", r_arb_owner);
        end
        n_checks++;
        if ({r_f_response, r_f_load_data, r_d_response} !== {R_DONE, 32'h13, R_IDLE}) begin
            n_fail++; $display("FAIL fetch_done got %h %h %h want 2 13 0", r_f_response, r_f_load_data, r_d_response);
        end
        tick();
    endtask

    task automatic test_tie;
        do_reset();
        f_cmd = C_EXEC;
        f_address = 32'h2000;
        d_cmd = C_LOAD;
        d_address = 32'h8000;
        @(negedge clk);
        n_checks++;
        if ({r_c_cmd, r_c_address, r_f_response} !== {C_LOAD, 32'h8000, R_WAIT}) begin
            n_fail++; $display("FAIL tie_first got %h %h %h want 2 8000 1", r_c_cmd, r_c_address, r_f_response);
        end
        tick();
        c_response = R_WAIT;
        @(negedge clk);
        n_checks++;
        if ({r_arb_owner, r_c_cmd, r_f_response} !== {2'd2, C_LOAD, R_WAIT}) begin
            n_fail++; $display("FAIL tie_busy got %h %h %h want 2 2 1", r_arb_owner, r_c_cmd, r_f_response);
        end
        tick();
        c_response = R_DONE;
        @(negedge clk);
        n_checks++;
        if ({r_d_response, r_c_cmd, r_c_address, r_f_response} !== {R_DONE, C_EXEC, 32'h2000, R_WAIT}) begin
            n_fail++; $display("FAIL tie_handover got %h %h %h %h want 2 1 2000 1", r_d_response, r_c_cmd, r_c_address, r_f_response);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({r_f_response, r_c_cmd, r_c_address} !== {R_DONE, C_LOAD, 32'h8000}) begin
            n_fail++; $display("FAIL tie_second got %h %h %h want 2 2 8000", r_f_response, r_c_cmd, r_c_address);
        end
        tick();
    endtask

    task automatic test_fixed_priority;
        do_reset();
        f_cmd = C_EXEC;
        f_address = 32'h2000;
        d_cmd = C_LOAD;
        d_address = 32'h8000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_checks++;
            if ({p_c_cmd, p_f_response} !== {C_LOAD, R_WAIT}) begin
                n_fail++; $display("FAIL fp_hold cyc %0d got %h %h want 2 1", i, p_c_cmd, p_f_response);
            end
            tick();
            c_response = (i % 2 == 0) ? R_WAIT : R_DONE;
        end
        d_cmd = C_NONE;
        c_response = R_DONE;
        @(negedge clk);
        n_checks++;
        if ({p_d_response, p_c_cmd, p_c_address} !== {R_DONE, C_EXEC, 32'h2000}) begin
            n_fail++; $display("FAIL fp_release got %h %h %h want 2 1 2000", p_d_response, p_c_cmd, p_c_address);
        end
        tick();
    endtask

    task automatic test_flush;
        do_reset();
        f_cmd = C_EXEC;
        f_address = 32'h2000;
        d_cmd = C_FLUSH;
        @(negedge clk);
        n_checks++;
        if (r_c_cmd !== C_FLUSH) begin
            n_fail++; $display("FAIL flush_grant got %h want 4", r_c_cmd);
        end
        tick();
        c_response = R_WAIT;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({r_c_cmd, r_f_response} !== {C_FLUSH, R_WAIT}) begin
                n_fail++; $display("FAIL flush_lock cyc %0d got %h %h want 4 1", i, r_c_cmd, r_f_response);
            end
            tick();
        end
        c_response = R_DONE;
        d_cmd = C_NONE;
        @(negedge clk);
        n_checks++;
        if ({r_d_response, r_c_cmd} !== {R_DONE, C_EXEC}) begin
            n_fail++; $display("FAIL flush_done got %h %h want 2 1", r_d_response, r_c_cmd);
        end
        tick();
    endtask

    task automatic test_pagefault;
        do_reset();
        f_cmd = C_EXEC;
        f_address = 32'h3000;
        tick();
        f_cmd = C_NONE;
        d_cmd = C_STORE;
        d_address = 32'h100;
        d_store_type = 2'd2;
        d_store_data = 32'hdead_beef;
        c_response = R_PF;
        @(negedge clk);
        n_checks++;
        if ({r_f_response, r_d_response} !== {R_PF, R_WAIT}) begin
            n_fail++; $display("FAIL pf_resp got %h %h want 5 1", r_f_response, r_d_response);
        end
        n_checks++;
        if ({r_c_cmd, r_c_store_type, r_c_store_data} !== {C_STORE, 2'd2, 32'hdead_beef}) begin
            n_fail++; $display("FAIL pf_grant got %h %h %h want 3 2 deadbeef", r_c_cmd, r_c_store_type, r_c_store_data);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        d_cmd = C_LOAD;
        d_address = 32'h8000;
        tick();
        c_response = R_WAIT;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({r_c_cmd, r_d_response} !== {C_NONE, R_IDLE}) begin
            n_fail++; $display("FAIL rstmid_now got %h %h want 0 0", r_c_cmd, r_d_response);
        end
        tick();
        rst = 1'b0;
        d_cmd = C_NONE;
        c_response = R_DONE;
        c_load_data = 32'h1234_5678;
        @(negedge clk);
        n_checks++;
        if ({r_arb_owner, r_d_response, r_d_load_data} !== {2'd0, R_IDLE, 32'd0}) begin
            n_fail++; $display("FAIL rstmid_drop got %h %h %h want 0 0 0", r_arb_owner, r_d_response, r_d_load_data);
        end
        tick();
        c_reset_done = 1'b0;
        c_response = R_IDLE;
        f_cmd = C_EXEC;
        d_cmd = C_LOAD;
        @(negedge clk);
        n_checks++;
        if ({r_c_cmd, r_f_response, r_d_response} !== {C_NONE, R_IDLE, R_IDLE}) begin
            n_fail++; $display("FAIL notready got %h %h %h want 0 0 0", r_c_cmd, r_f_response, r_d_response);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (r_arb_owner !== 2'd0) begin
            n_fail++; $display("FAIL notready_owner got %0d want 0", r_arb_owner);
        end
        c_reset_done = 1'b1;
        tick();
    endtask

    task automatic test_random(input int cycles);
        int mo_r, ml_r, mo_p, ml_p, g;
        logic [146:0] exp_v, act_v;
        do_reset();
        mo_r = 0; ml_r = 1; mo_p = 0; ml_p = 1;
        for (int i = 0; i < cycles; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            c_reset_done = ($urandom_range(0, 24) != 0);
            f_cmd = ($urandom_range(0, 9) < 4) ? C_NONE : 4'($urandom_range(1, 4));
            d_cmd = ($urandom_range(0, 9) < 4) ? C_NONE : 4'($urandom_range(1, 4));
            f_address = $urandom;
            d_address = $urandom;
            d_load_type = 3'($urandom);
            d_store_type = 2'($urandom);
            d_store_data = $urandom;
            c_response = ($urandom_range(0, 9) < 5) ? R_WAIT : 4'($urandom_range(0, 5));
            c_load_data = $urandom;
            @(negedge clk);
            exp_v = model_out(1'b1, mo_r, ml_r);
            act_v = {r_c_cmd, r_c_address, r_c_load_type, r_c_store_type, r_c_store_data,
                     r_f_response, r_f_load_data, r_d_response, r_d_load_data, r_arb_owner};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL rr_random cyc %0d got %h want %h", i, act_v, exp_v);
            end
            exp_v = model_out(1'b0, mo_p, ml_p);
            act_v = {p_c_cmd, p_c_address, p_c_load_type, p_c_store_type, p_c_store_data,
                     p_f_response, p_f_load_data, p_d_response, p_d_load_data, p_arb_owner};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++; $display("FAIL fp_random cyc %0d got %h want %h", i, act_v, exp_v);
            end
            if (rst) begin
                mo_r = 0; ml_r = 1; mo_p = 0; ml_p = 1;
            end else begin
                g = model_gnt(1'b1, mo_r, ml_r);
                mo_r = g;
                if (g != 0) ml_r = g;
                g = model_gnt(1'b0, mo_p, ml_p);
                mo_p = g;
                if (g != 0) ml_p = g;
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        c_reset_done = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch_only();
        test_tie();
        test_fixed_priority();
        test_flush();
        test_pagefault();
        test_reset_mid();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
